// File: rtl/ethernet_tx_reply_scheduler.sv
// ethernet_tx_reply_scheduler
//   Shares one 8-bit TX byte stream between the ARP and UDP reply builders.
//   Each builder's one-cycle ready pulse is latched into a shadow buffer with a
//   pending flag. Pending sources are granted round-robin, and each frame is sent
//   MSB-first as head (50 bytes), payload (N bytes) and then zero pad up to
//   MIN_FRAME_BYTES. An inter-frame gap follows every frame. CRC is added downstream.
//
// Ports
//   i_clk, i_reset        clock, async active-high reset
//   i_arp_ready/head      ARP request pulse and 50-byte frame
//   i_udp_ready/head/payload/payload_size
//                         UDP request pulse, 50-byte head, left-aligned payload, size
//   o_tx_data/valid/sof/eof
//                         serial byte stream with frame delimiters
//   o_busy                scheduler not idle
//   o_overflow            1-cycle pulse when a request was dropped
//   o_grant               source of current frame (0=ARP, 1=UDP)
//
// Optional build macro: ETH_TX_SCHED_STATS_EN adds o_frames_sent (wrapping count
// of EOFs) and o_drops (saturating count of overflow pulses).
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for a pending request; grants and loads the active regs
//   HEAD    | sending the 50 head bytes (SOF on the first)
//   PAYLOAD | sending the N payload bytes
//   PAD     | sending 0x00 until the minimum frame length is reached
//   GAP     | inter-frame gap, o_tx_valid held low

module ethernet_tx_reply_scheduler #(
    parameter int IFG_CYCLES      = 12,
    parameter int MIN_FRAME_BYTES = 68,
    parameter int MAX_PAYLOAD     = 63
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_arp_ready,
    input  logic [399:0] i_arp_head,
    input  logic         i_udp_ready,
    input  logic [399:0] i_udp_head,
    input  logic [503:0] i_udp_payload,
    input  logic [15:0]  i_udp_payload_size,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    output logic         o_tx_sof,
    output logic         o_tx_eof,
    output logic         o_busy,
    output logic         o_overflow,
`ifdef ETH_TX_SCHED_STATS_EN
    output logic [15:0]  o_frames_sent,
    output logic [7:0]   o_drops,
`endif
    output logic         o_grant
);

    localparam int HEAD_BYTES = 50;
    localparam int HEAD_W     = HEAD_BYTES * 8;
    localparam int PAY_W      = MAX_PAYLOAD * 8;
    localparam int N_W        = $clog2(MAX_PAYLOAD + 1);
    localparam int GAP_W      = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEAD    = 3'd1,
        PAYLOAD = 3'd2,
        PAD     = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t             state;
    logic [6:0]         byte_cnt;
    logic [6:0]         last_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_grant;

    logic               pend_arp;
    logic               pend_udp;
    logic [HEAD_W-1:0]  arp_head_sh;
    logic [HEAD_W-1:0]  udp_head_sh;
    logic [PAY_W-1:0]   udp_pay_sh;
    logic [N_W-1:0]     udp_n_sh;

    logic [HEAD_W-1:0]  head_sr;
    logic [PAY_W-1:0]   pay_sr;
    logic [N_W-1:0]     n_act;

    logic               do_grant;
    logic               sel_udp;
    logic               take_arp;
    logic               take_udp;
    logic               acc_arp;
    logic               acc_udp;
    logic [N_W-1:0]     udp_n_clamped;
    logic [6:0]         udp_sum;
    logic [6:0]         udp_last;
    logic               is_last;

    always_comb begin
        do_grant = 1'b0;
        sel_udp  = 1'b0;
        if (state == IDLE && (pend_arp || pend_udp)) begin
            do_grant = 1'b1;
            // With both pending, whoever did not go last wins.
            sel_udp  = (pend_arp && pend_udp) ? ~last_grant : pend_udp;
        end
    end

    assign take_arp = do_grant & ~sel_udp;
    assign take_udp = do_grant & sel_udp;

    // A pulse arriving on the same edge that its source's shadow is granted is
    // accepted: the old shadow goes out and the new request becomes pending.
    assign acc_arp = i_arp_ready & (~pend_arp | take_arp);
    assign acc_udp = i_udp_ready & (~pend_udp | take_udp);

    assign udp_n_clamped = (i_udp_payload_size > 16'(MAX_PAYLOAD)) ? N_W'(MAX_PAYLOAD)
                                                                  : i_udp_payload_size[N_W-1:0];

    assign udp_sum  = 7'(HEAD_BYTES) + 7'(udp_n_sh);
    assign udp_last = (udp_sum < 7'(MIN_FRAME_BYTES)) ? 7'(MIN_FRAME_BYTES - 1)
                                                      : udp_sum - 7'd1;

    assign is_last = (byte_cnt == last_idx);
    assign o_busy  = (state != IDLE);

    // Request capture: shadow buffers, pending flags and drop reporting.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pend_arp    <= 1'b0;
            pend_udp    <= 1'b0;
            arp_head_sh <= '0;
            udp_head_sh <= '0;
            udp_pay_sh  <= '0;
            udp_n_sh    <= '0;
            o_overflow  <= 1'b0;
        end else begin
            if (take_arp) pend_arp <= 1'b0;
            if (take_udp) pend_udp <= 1'b0;
            if (acc_arp) begin
                pend_arp    <= 1'b1;
                arp_head_sh <= i_arp_head;
            end
            if (acc_udp) begin
                pend_udp    <= 1'b1;
                udp_head_sh <= i_udp_head;
                udp_pay_sh  <= i_udp_payload[503 -: PAY_W];
                udp_n_sh    <= udp_n_clamped;
            end
            o_overflow <= (i_arp_ready & ~acc_arp) | (i_udp_ready & ~acc_udp);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            last_idx   <= '0;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            o_grant    <= 1'b0;
            head_sr    <= '0;
            pay_sr     <= '0;
            n_act      <= '0;
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_tx_sof   <= 1'b0;
            o_tx_eof   <= 1'b0;
        end else begin
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_tx_sof   <= 1'b0;
            o_tx_eof   <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        state      <= HEAD;
                        byte_cnt   <= '0;
                        last_grant <= sel_udp;
                        o_grant    <= sel_udp;
                        if (sel_udp) begin
                            head_sr  <= udp_head_sh;
                            pay_sr   <= udp_pay_sh;
                            n_act    <= udp_n_sh;
                            last_idx <= udp_last;
                        end else begin
                            head_sr  <= arp_head_sh;
                            pay_sr   <= '0;
                            n_act    <= '0;
                            last_idx <= 7'(MIN_FRAME_BYTES - 1);
                        end
                    end
                end
                HEAD, PAYLOAD, PAD: begin
                    o_tx_valid <= 1'b1;
                    o_tx_sof   <= (byte_cnt == 7'd0);
                    o_tx_eof   <= is_last;
                    byte_cnt   <= byte_cnt + 7'd1;
                    if (state == HEAD) begin
                        o_tx_data <= head_sr[HEAD_W-1 -: 8];
                        head_sr   <= {head_sr[HEAD_W-9:0], 8'h00};
                    end else if (state == PAYLOAD) begin
                        o_tx_data <= pay_sr[PAY_W-1 -: 8];
                        pay_sr    <= {pay_sr[PAY_W-9:0], 8'h00};
                    end
                    if (is_last) begin
                        state   <= GAP;
                        gap_cnt <= GAP_W'(IFG_CYCLES);
                    end else if (state == HEAD && byte_cnt == 7'(HEAD_BYTES - 1)) begin
                        state <= (n_act != '0) ? PAYLOAD : PAD;
                    end else if (state == PAYLOAD &&
                                 byte_cnt == 7'(HEAD_BYTES - 1) + 7'(n_act)) begin
                        state <= PAD;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt <= GAP_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ETH_TX_SCHED_STATS_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_frames_sent <= '0;
            o_drops       <= '0;
        end else begin
            if (o_tx_valid && o_tx_eof) o_frames_sent <= o_frames_sent + 16'd1;
            if (o_overflow && o_drops != 8'hFF) o_drops <= o_drops + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ethernet_tx_reply_scheduler.sv
module tb_ethernet_tx_reply_scheduler;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_arp_ready;
    logic [399:0] i_arp_head;
    logic         i_udp_ready;
    logic [399:0] i_udp_head;
    logic [503:0] i_udp_payload;
    logic [15:0]  i_udp_payload_size;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         o_tx_sof;
    logic         o_tx_eof;
    logic         o_busy;
    logic         o_overflow;
    logic         o_grant;
`ifdef ETH_TX_SCHED_STATS_EN
    logic [15:0]  o_frames_sent;
    logic [7:0]   o_drops;
`endif

    int checks = 0;
    int errors = 0;

    ethernet_tx_reply_scheduler dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_arp_ready        (i_arp_ready),
        .i_arp_head         (i_arp_head),
        .i_udp_ready        (i_udp_ready),
        .i_udp_head         (i_udp_head),
        .i_udp_payload      (i_udp_payload),
        .i_udp_payload_size (i_udp_payload_size),
        .o_tx_data          (o_tx_data),
        .o_tx_valid         (o_tx_valid),
        .o_tx_sof           (o_tx_sof),
        .o_tx_eof           (o_tx_eof),
        .o_busy             (o_busy),
        .o_overflow         (o_overflow),
`ifdef ETH_TX_SCHED_STATS_EN
        .o_frames_sent      (o_frames_sent),
        .o_drops            (o_drops),
`endif
        .o_grant            (o_grant)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Head byte 0 is the preamble 0x55, byte i is tag+i.
    function automatic logic [399:0] mk_head(input logic [7:0] t);
        logic [399:0] h;
        for (int i = 0; i < 50; i++)
            h[399-8*i -: 8] = (i == 0) ? 8'h55 : t + 8'(i);
        return h;
    endfunction

    function automatic logic [503:0] mk_pay(input logic [7:0] b);
        logic [503:0] p;
        for (int j = 0; j < 63; j++)
            p[503-8*j -: 8] = b + 8'(j);
        return p;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] ht, input logic [7:0] pb,
                                            input int n, input int idx);
        if (idx == 0)      return 8'h55;
        if (idx < 50)      return ht + 8'(idx);
        if (idx < 50 + n)  return pb + 8'(idx - 50);
        return 8'h00;
    endfunction

    // All pulse tasks are entered at a falling edge and return one falling edge later.
    task automatic pulse_udp(input logic [7:0] t, input logic [7:0] pb, input logic [15:0] sz);
        i_udp_head = mk_head(t);
        i_udp_payload = mk_pay(pb);
        i_udp_payload_size = sz;
        i_udp_ready = 1'b1;
        @(negedge i_clk);
        i_udp_ready = 1'b0;
    endtask

    task automatic pulse_arp(input logic [7:0] t);
        i_arp_head = mk_head(t);
        i_arp_ready = 1'b1;
        @(negedge i_clk);
        i_arp_ready = 1'b0;
    endtask

    task automatic pulse_both(input logic [7:0] at, input logic [7:0] ut,
                              input logic [7:0] pb, input logic [15:0] sz);
        i_arp_head = mk_head(at);
        i_udp_head = mk_head(ut);
        i_udp_payload = mk_pay(pb);
        i_udp_payload_size = sz;
        i_arp_ready = 1'b1;
        i_udp_ready = 1'b1;
        @(negedge i_clk);
        i_arp_ready = 1'b0;
        i_udp_ready = 1'b0;
    endtask

    // Waits for SOF, checks every byte (valid/sof/eof/data) and the 12-cycle gap.
    task automatic get_frame(input string tag, input logic exp_grant, input logic [7:0] ht,
                             input logic [7:0] pb, input int n);
        int total;
        int t;
        total = (50 + n < 68) ? 68 : 50 + n;
        t = 0;
        while (!(o_tx_valid === 1'b1 && o_tx_sof === 1'b1) && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        check_val({tag, "_sof_seen"}, 32'(t < 3000), 32'd1);
        if (t >= 3000) return;
        check_val({tag, "_grant"}, 32'(o_grant), 32'(exp_grant));
        for (int idx = 0; idx < total; idx++) begin
            check_val($sformatf("%s_byte%0d", tag, idx),
                      {21'd0, o_tx_valid, o_tx_sof, o_tx_eof, o_tx_data},
                      {21'd0, 1'b1, idx == 0, idx == total - 1, exp_byte(ht, pb, n, idx)});
            @(negedge i_clk);
        end
        for (int g = 0; g < 12; g++) begin
            check_val($sformatf("%s_gap%0d", tag, g), {23'd0, o_tx_valid, o_tx_data}, 32'd0);
            @(negedge i_clk);
        end
    endtask

    initial begin
        int vcount;
        i_reset = 1'b1;
        i_arp_ready = 1'b0;
        i_udp_ready = 1'b0;
        i_arp_head = '0;
        i_udp_head = '0;
        i_udp_payload = '0;
        i_udp_payload_size = '0;
        repeat (2) @(negedge i_clk);
        check_val("reset_outputs",
                  {20'd0, o_tx_valid, o_tx_sof, o_tx_eof, o_busy, o_overflow, o_grant, o_tx_data[1:0]},
                  32'd0);
        check_val("reset_data", 32'(o_tx_data), 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Simultaneous requests after reset: ARP first, then UDP; repeat alternates again.
        pulse_both(8'h30, 8'h10, 8'hA0, 16'd4);
        get_frame("both1_arp", 1'b0, 8'h30, 8'h00, 0);
        get_frame("both1_udp", 1'b1, 8'h10, 8'hA0, 4);
        pulse_both(8'h31, 8'h11, 8'hA8, 16'd2);
        get_frame("both2_arp", 1'b0, 8'h31, 8'h00, 0);
        get_frame("both2_udp", 1'b1, 8'h11, 8'hA8, 2);

        // UDP N=10 with latency check: SOF valid after the second edge past the pulse.
        pulse_udp(8'h20, 8'h80, 16'd10);
        check_val("lat_edge0_valid", 32'(o_tx_valid), 32'd0);
        @(negedge i_clk);
        check_val("lat_edge1", {30'd0, o_tx_valid, o_busy}, 32'd1);
        @(negedge i_clk);
        check_val("lat_edge2_sof", {30'd0, o_tx_valid, o_tx_sof}, 32'd3);
        get_frame("udp_n10", 1'b1, 8'h20, 8'h80, 10);

        // N=63 fills to 113 bytes, N=70 clamps to 63, N=0 is all pad after the head.
        pulse_udp(8'h40, 8'h01, 16'd63);
        get_frame("udp_n63", 1'b1, 8'h40, 8'h01, 63);
        pulse_udp(8'h41, 8'h90, 16'd70);
        get_frame("udp_n70", 1'b1, 8'h41, 8'h90, 63);
        pulse_udp(8'h42, 8'h00, 16'd0);
        get_frame("udp_n0", 1'b1, 8'h42, 8'h00, 0);

        // Second pulse on the grant edge of the same source is kept, not dropped.
        pulse_udp(8'h50, 8'h60, 16'd1);
        pulse_udp(8'h51, 8'h70, 16'd20);
        check_val("regrant_no_ovf", 32'(o_overflow), 32'd0);
        get_frame("regrant_a", 1'b1, 8'h50, 8'h60, 1);
        get_frame("regrant_b", 1'b1, 8'h51, 8'h70, 20);

        // UDP active, ARP and UDP2 pending, UDP3 dropped with a one-cycle overflow.
        pulse_udp(8'h10, 8'hA0, 16'd5);
        fork
            begin
                get_frame("seq_udp1", 1'b1, 8'h10, 8'hA0, 5);
                get_frame("seq_arp",  1'b0, 8'h60, 8'h00, 0);
                get_frame("seq_udp2", 1'b1, 8'h20, 8'hB0, 3);
            end
            begin
                repeat (5) @(negedge i_clk);
                pulse_arp(8'h60);
                repeat (5) @(negedge i_clk);
                pulse_udp(8'h20, 8'hB0, 16'd3);
                check_val("seq_udp2_no_ovf", 32'(o_overflow), 32'd0);
                repeat (5) @(negedge i_clk);
                pulse_udp(8'h70, 8'hC0, 16'd7);
                check_val("seq_udp3_ovf", 32'(o_overflow), 32'd1);
                @(negedge i_clk);
                check_val("seq_ovf_one_cycle", 32'(o_overflow), 32'd0);
            end
        join

        // Reset at byte 30 abandons the frame and clears the pending ARP request.
        pulse_udp(8'h33, 8'h44, 16'd10);
        pulse_arp(8'h66);
        while (!(o_tx_valid === 1'b1 && o_tx_sof === 1'b1)) @(negedge i_clk);
        repeat (30) @(negedge i_clk);
        check_val("rst_pre_valid", 32'(o_tx_valid), 32'd1);
        i_reset = 1'b1;
        #1;
        check_val("rst_valid_drop", {30'd0, o_tx_valid, o_busy}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        vcount = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge i_clk);
            if (o_tx_valid === 1'b1) vcount++;
        end
        check_val("rst_pending_cleared", 32'(vcount), 32'd0);
        pulse_udp(8'h77, 8'h12, 16'd10);
        get_frame("post_rst", 1'b1, 8'h77, 8'h12, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
